// File: rtl/isu_refill_scheduler.sv
// Issue stage: in-order reorder buffer that matches out-of-order refills by nline id and issues
// to the data-array port under per-channel credits. Define ISU_REFILL_BYPASS_EN for refill bypass.
module isu_refill_scheduler #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned SET_W     = 3,
  parameter int unsigned WAY_W     = 2,
  parameter int unsigned NLINE_W   = 5,
  parameter int unsigned OFFSET_W  = 1,
  parameter int unsigned WBUF_W    = 7,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned CRDT_MAX  = 4,
  localparam int unsigned ROB_W    = $clog2(ROB_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   u_htu_valid_i,
  output logic                   u_htu_ready_o,
  input  logic [NUM_CH-1:0]      u_htu_channel_1hot_id_i,
  input  logic [2:0]             u_htu_op_i,
  input  logic [NLINE_W-1:0]     u_htu_id_i,
  input  logic [OFFSET_W-1:0]    u_htu_offset_i,
  input  logic [WBUF_W-1:0]      u_htu_wbuf_id_i,
  input  logic [SET_W-1:0]       u_htu_set_i,
  input  logic [WAY_W-1:0]       u_htu_way_i,
  input  logic                   u_htu_miss_i,
  input  logic                   memctl_refill_valid_i,
  output logic                   memctl_refill_ready_o,
  input  logic [NLINE_W-1:0]     memctl_refill_id_i,
  input  logic [DATA_W-1:0]      memctl_refill_data_i,
  input  logic [NUM_CH-1:0]      u_xbar_crdt_rtn_i,
  output logic                   d_rc_valid_o,
  input  logic                   d_rc_ready_i,
  output logic [NUM_CH-1:0]      d_rc_channel_1hot_id_o,
  output logic [ROB_W-1:0]       d_rc_rob_id_o,
  output logic [2:0]             d_rc_op_o,
  output logic [SET_W-1:0]       d_rc_set_o,
  output logic [WAY_W-1:0]       d_rc_way_o,
  output logic [WBUF_W-1:0]      d_rc_wbuf_id_o,
  output logic [DATA_W-1:0]      d_rc_refill_data_o,
  output logic                   u_htu_crdt_valid_o,
  output logic [WAY_W+SET_W-1:0] u_htu_crdt_way_set_o,
  output logic                   err_orphan_refill_o
);

  localparam int unsigned CRDT_W = $clog2(CRDT_MAX + 1);

  logic [ROB_W:0]          head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0]    vld_q, wait_q;
  logic [NUM_CH-1:0]       ch_q   [ROB_DEPTH];
  logic [2:0]              op_q   [ROB_DEPTH];
  logic [NLINE_W-1:0]      id_q   [ROB_DEPTH];
  logic [WBUF_W-1:0]       wbuf_q [ROB_DEPTH];
  logic [SET_W-1:0]        set_q  [ROB_DEPTH];
  logic [WAY_W-1:0]        way_q  [ROB_DEPTH];
  logic [DATA_W-1:0]       data_q [ROB_DEPTH];
  logic [CRDT_W-1:0]       crdt_q [NUM_CH];
  logic [CRDT_W-1:0]       crdt_d [NUM_CH];
  logic                    ready_q, refill_ready_q, crdt_valid_q, err_q;
  logic [WAY_W+SET_W-1:0]  crdt_ws_q, oldest_ws;

  logic [ROB_W-1:0]        head_idx, tail_idx;
  logic [ROB_DEPTH-1:0]    match_vec, hum_vec;
  logic [NUM_CH-1:0]       alloc_ch, crdt_nz;
  logic                    alloc, refill_fire, alloc_wait, alloc_match, any_match;
  logic                    credit_ok, bypass_hit, issue_valid, issue_fire, full_d;
  logic                    unused_offset;

  assign unused_offset = ^u_htu_offset_i;

  assign head_idx    = head_q[ROB_W-1:0];
  assign tail_idx    = tail_q[ROB_W-1:0];
  assign alloc       = u_htu_valid_i & ready_q;
  assign refill_fire = memctl_refill_valid_i & refill_ready_q;
  // Non-one-hot channel ids collapse to their lowest set bit.
  assign alloc_ch    = u_htu_channel_1hot_id_i & (~u_htu_channel_1hot_id_i + NUM_CH'(1));

  always_comb begin
    match_vec = '0;
    hum_vec   = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      match_vec[i] = vld_q[i] & wait_q[i] & (id_q[i] == memctl_refill_id_i) & refill_fire;
      hum_vec[i]   = vld_q[i] & wait_q[i] & (id_q[i] == u_htu_id_i);
    end
  end

  assign alloc_wait  = u_htu_miss_i | (|hum_vec);
  assign alloc_match = alloc & alloc_wait & refill_fire & (u_htu_id_i == memctl_refill_id_i);
  assign any_match   = (|match_vec) | alloc_match;

  // Walk from head so the first hit is the oldest waiter; the new alloc is youngest.
  always_comb begin
    logic             found;
    logic [ROB_W-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    oldest_ws = {u_htu_way_i, u_htu_set_i};
    for (int k = 0; k < ROB_DEPTH; k++) begin
      idx = head_idx + ROB_W'(k);
      if (!found && match_vec[idx]) begin
        found     = 1'b1;
        oldest_ws = {way_q[idx], set_q[idx]};
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) crdt_nz[c] = (crdt_q[c] != '0);
  end

  assign credit_ok = |(ch_q[head_idx] & crdt_nz);

`ifdef ISU_REFILL_BYPASS_EN
  assign bypass_hit = refill_fire & vld_q[head_idx] & wait_q[head_idx] &
                      (id_q[head_idx] == memctl_refill_id_i);
`else
  assign bypass_hit = 1'b0;
`endif

  assign issue_valid = vld_q[head_idx] & credit_ok & (~wait_q[head_idx] | bypass_hit);
  assign issue_fire  = issue_valid & d_rc_ready_i;

  assign head_d = head_q + (ROB_W + 1)'(issue_fire);
  assign tail_d = tail_q + (ROB_W + 1)'(alloc);
  assign full_d = (head_d[ROB_W-1:0] == tail_d[ROB_W-1:0]) & (head_d[ROB_W] != tail_d[ROB_W]);

  // Simultaneous issue and return on one channel cancel out.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      crdt_d[c] = crdt_q[c];
      if (u_xbar_crdt_rtn_i[c] && !(issue_fire && ch_q[head_idx][c])) begin
        if (crdt_q[c] < CRDT_W'(CRDT_MAX)) crdt_d[c] = crdt_q[c] + CRDT_W'(1);
      end else if (!u_xbar_crdt_rtn_i[c] && issue_fire && ch_q[head_idx][c]) begin
        crdt_d[c] = crdt_q[c] - CRDT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      vld_q          <= '0;
      wait_q         <= '0;
      ready_q        <= 1'b0;
      refill_ready_q <= 1'b0;
      crdt_valid_q   <= 1'b0;
      crdt_ws_q      <= '0;
      err_q          <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) crdt_q[c] <= CRDT_W'(CRDT_MAX);
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      ready_q        <= ~full_d;
      refill_ready_q <= 1'b1;
      crdt_valid_q   <= refill_fire & any_match;
      crdt_ws_q      <= (refill_fire & any_match) ? oldest_ws : '0;
      if (refill_fire && !any_match) err_q <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) crdt_q[c] <= crdt_d[c];
      wait_q <= wait_q & ~match_vec;
      if (issue_fire) vld_q[head_idx] <= 1'b0;
      if (alloc) begin
        vld_q[tail_idx]  <= 1'b1;
        wait_q[tail_idx] <= alloc_wait & ~alloc_match;
      end
    end
  end

  // Payload needs no reset: it is only observed behind a valid entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (match_vec[i]) data_q[i] <= memctl_refill_data_i;
    end
    if (alloc) begin
      ch_q[tail_idx]   <= alloc_ch;
      op_q[tail_idx]   <= u_htu_op_i;
      id_q[tail_idx]   <= u_htu_id_i;
      wbuf_q[tail_idx] <= u_htu_wbuf_id_i;
      set_q[tail_idx]  <= u_htu_set_i;
      way_q[tail_idx]  <= u_htu_way_i;
      data_q[tail_idx] <= alloc_match ? memctl_refill_data_i : '0;
    end
  end

  assign u_htu_ready_o          = ready_q;
  assign memctl_refill_ready_o  = refill_ready_q;
  assign u_htu_crdt_valid_o     = crdt_valid_q;
  assign u_htu_crdt_way_set_o   = crdt_ws_q;
  assign err_orphan_refill_o    = err_q;
  assign d_rc_valid_o           = issue_valid;
  assign d_rc_channel_1hot_id_o = issue_valid ? ch_q[head_idx] : '0;
  assign d_rc_rob_id_o          = issue_valid ? head_idx : '0;
  assign d_rc_op_o              = issue_valid ? op_q[head_idx] : '0;
  assign d_rc_set_o             = issue_valid ? set_q[head_idx] : '0;
  assign d_rc_way_o             = issue_valid ? way_q[head_idx] : '0;
  assign d_rc_wbuf_id_o         = issue_valid ? wbuf_q[head_idx] : '0;
  assign d_rc_refill_data_o     = !issue_valid ? '0 :
                                  bypass_hit ? memctl_refill_data_i : data_q[head_idx];

endmodule

// File: tb/tb_isu_refill_scheduler.sv
// Directed bench for isu_refill_scheduler (default build, bypass disabled).
module tb_isu_refill_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         u_htu_valid, u_htu_ready;
  logic [2:0]   u_htu_ch, u_htu_op;
  logic [4:0]   u_htu_id;
  logic [0:0]   u_htu_offset;
  logic [6:0]   u_htu_wbuf;
  logic [2:0]   u_htu_set;
  logic [1:0]   u_htu_way;
  logic         u_htu_miss;
  logic         rf_valid, rf_ready;
  logic [4:0]   rf_id;
  logic [127:0] rf_data;
  logic [2:0]   xbar_rtn;
  logic         d_valid, d_ready;
  logic [2:0]   d_ch, d_op;
  logic [3:0]   d_rob;
  logic [2:0]   d_set;
  logic [1:0]   d_way;
  logic [6:0]   d_wbuf;
  logic [127:0] d_data;
  logic         crdt_valid;
  logic [4:0]   crdt_ws;
  logic         err;

  int ntests = 0;
  int nfail  = 0;

  localparam logic [127:0] DataA = 128'hffff_eeee_ffff_eeee;
  localparam logic [127:0] DataB = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
  localparam logic [127:0] DataC = 128'hdead_beef_0000_0001;

  always #5 clk = ~clk;

  isu_refill_scheduler dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .u_htu_valid_i          (u_htu_valid),
    .u_htu_ready_o          (u_htu_ready),
    .u_htu_channel_1hot_id_i(u_htu_ch),
    .u_htu_op_i             (u_htu_op),
    .u_htu_id_i             (u_htu_id),
    .u_htu_offset_i         (u_htu_offset),
    .u_htu_wbuf_id_i        (u_htu_wbuf),
    .u_htu_set_i            (u_htu_set),
    .u_htu_way_i            (u_htu_way),
    .u_htu_miss_i           (u_htu_miss),
    .memctl_refill_valid_i  (rf_valid),
    .memctl_refill_ready_o  (rf_ready),
    .memctl_refill_id_i     (rf_id),
    .memctl_refill_data_i   (rf_data),
    .u_xbar_crdt_rtn_i      (xbar_rtn),
    .d_rc_valid_o           (d_valid),
    .d_rc_ready_i           (d_ready),
    .d_rc_channel_1hot_id_o (d_ch),
    .d_rc_rob_id_o          (d_rob),
    .d_rc_op_o              (d_op),
    .d_rc_set_o             (d_set),
    .d_rc_way_o             (d_way),
    .d_rc_wbuf_id_o         (d_wbuf),
    .d_rc_refill_data_o     (d_data),
    .u_htu_crdt_valid_o     (crdt_valid),
    .u_htu_crdt_way_set_o   (crdt_ws),
    .err_orphan_refill_o    (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_htu_valid = 1'b0; u_htu_ch = '0; u_htu_op = '0; u_htu_id = '0; u_htu_offset = '0;
    u_htu_wbuf = '0; u_htu_set = '0; u_htu_way = '0; u_htu_miss = 1'b0;
    rf_valid = 1'b0; rf_id = '0; rf_data = '0; xbar_rtn = '0;
  endtask

  task automatic req(input logic [2:0] ch, input logic [4:0] id, input logic [2:0] set,
                     input logic [1:0] way, input logic [6:0] wbuf, input logic miss);
    u_htu_valid = 1'b1; u_htu_ch = ch; u_htu_op = 3'd1; u_htu_id = id;
    u_htu_set = set; u_htu_way = way; u_htu_wbuf = wbuf; u_htu_miss = miss;
  endtask

  task automatic refill(input logic [4:0] id, input logic [127:0] data);
    rf_valid = 1'b1; rf_id = id; rf_data = data;
  endtask

  task automatic do_reset();
    idle();
    d_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_htu_ready", u_htu_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_rf_ready", rf_ready, 0);
    chk("rst_crdt_valid", crdt_valid, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_htu_ready", u_htu_ready, 1);
    chk("post_rst_rf_ready", rf_ready, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    d_ready = 1'b1;
    idle();
    #2;

    // Hit on channel 'b010 into empty ROB.
    do_reset();
    req(3'b010, 5'd0, 3'd5, 2'd3, 7'd7, 1'b0);
    chk("t1_valid_n", d_valid, 0);
    tick();
    idle();
    chk("t1_valid_n1", d_valid, 1);
    chk("t1_rob", d_rob, 0);
    chk("t1_set", d_set, 5);
    chk("t1_way", d_way, 3);
    chk("t1_wbuf", d_wbuf, 7);
    chk("t1_ch", d_ch, 3'b010);
    chk("t1_op", d_op, 1);
    chk("t1_data", d_data, 0);
    tick();
    chk("t1_drained", d_valid, 0);

    // Miss then hit-under-miss on id {2,6}; one refill releases both.
    do_reset();
    req(3'b001, {2'd2, 3'd6}, 3'd6, 2'd2, 7'd1, 1'b1);
    tick();
    req(3'b001, {2'd2, 3'd6}, 3'd6, 2'd2, 7'd2, 1'b0);
    tick();
    idle();
    chk("t2_wait0", d_valid, 0);
    tick();
    chk("t2_wait1", d_valid, 0);
    refill({2'd2, 3'd6}, DataA);
    chk("t2_rf_ready", rf_ready, 1);
    chk("t2_no_bypass", d_valid, 0);
    tick();
    idle();
    chk("t2_crdt_valid", crdt_valid, 1);
    chk("t2_crdt_ws", crdt_ws, {2'd2, 3'd6});
    chk("t2_first_valid", d_valid, 1);
    chk("t2_first_rob", d_rob, 0);
    chk("t2_first_wbuf", d_wbuf, 1);
    chk("t2_first_data", d_data, DataA);
    tick();
    chk("t2_crdt_pulse", crdt_valid, 0);
    chk("t2_second_valid", d_valid, 1);
    chk("t2_second_rob", d_rob, 1);
    chk("t2_second_wbuf", d_wbuf, 2);
    chk("t2_second_data", d_data, DataA);
    tick();
    chk("t2_drained", d_valid, 0);
    chk("t2_err", err, 0);

    // Out-of-order refills: younger line first must not issue past the head.
    do_reset();
    req(3'b100, {2'd3, 3'd5}, 3'd5, 2'd3, 7'd3, 1'b1);
    tick();
    req(3'b100, {2'd1, 3'd3}, 3'd3, 2'd1, 7'd4, 1'b1);
    tick();
    idle();
    refill({2'd1, 3'd3}, DataB);
    tick();
    idle();
    chk("t3_crdt_b", crdt_valid, 1);
    chk("t3_crdt_b_ws", crdt_ws, {2'd1, 3'd3});
    chk("t3_held", d_valid, 0);
    refill({2'd3, 3'd5}, DataC);
    tick();
    idle();
    chk("t3_crdt_a_ws", crdt_ws, {2'd3, 3'd5});
    chk("t3_a_valid", d_valid, 1);
    chk("t3_a_wbuf", d_wbuf, 3);
    chk("t3_a_data", d_data, DataC);
    tick();
    chk("t3_b_valid", d_valid, 1);
    chk("t3_b_rob", d_rob, 1);
    chk("t3_b_wbuf", d_wbuf, 4);
    chk("t3_b_data", d_data, DataB);
    tick();
    chk("t3_drained", d_valid, 0);

    // Five hits on channel 0 with four credits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(3'b001, 5'(i), 3'd0, 2'd0, 7'(10 + i), 1'b0);
      if (i == 0) chk("t4_valid_first", d_valid, 0);
      else chk("t4_issue_wbuf", {d_valid, d_wbuf}, {1'b1, 7'(9 + i)});
      tick();
    end
    idle();
    chk("t4_starved", d_valid, 0);
    tick();
    chk("t4_starved2", d_valid, 0);
    xbar_rtn = 3'b001;
    chk("t4_rtn_cycle", d_valid, 0);
    tick();
    xbar_rtn = 3'b000;
    chk("t4_fifth_valid", d_valid, 1);
    chk("t4_fifth_wbuf", d_wbuf, 14);
    chk("t4_fifth_rob", d_rob, 4);
    tick();
    chk("t4_drained", d_valid, 0);

    // Fill all 16 entries, free one, refill to wrap the tail.
    do_reset();
    d_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t5_ready_fill", u_htu_ready, 1);
      req(3'b001, 5'd0, 3'd1, 2'd1, 7'(i), 1'b0);
      tick();
    end
    idle();
    chk("t5_full", u_htu_ready, 0);
    chk("t5_stall_valid", d_valid, 1);
    tick();
    chk("t5_stall_rob", {d_valid, d_rob, d_wbuf}, {1'b1, 4'd0, 7'd0});
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    chk("t5_ready_again", u_htu_ready, 1);
    chk("t5_next_head", d_rob, 1);
    req(3'b001, 5'd0, 3'd1, 2'd1, 7'd100, 1'b0);
    tick();
    idle();
    chk("t5_full_again", u_htu_ready, 0);
    d_ready = 1'b1;
    xbar_rtn = 3'b111;
    for (int i = 1; i < 16; i++) begin
      chk("t5_drain", {d_valid, d_rob, d_wbuf}, {1'b1, 4'(i), 7'(i)});
      tick();
    end
    xbar_rtn = 3'b000;
    chk("t5_wrap_entry", {d_valid, d_rob, d_wbuf}, {1'b1, 4'd0, 7'd100});
    tick();
    chk("t5_drained", d_valid, 0);
    chk("t5_ready_end", u_htu_ready, 1);

    // Non-one-hot channel collapses to lowest set bit.
    do_reset();
    req(3'b110, 5'd9, 3'd2, 2'd1, 7'd55, 1'b0);
    tick();
    idle();
    chk("t6_ch_lowbit", {d_valid, d_ch}, {1'b1, 3'b010});
    tick();

    // Orphan refill sets a sticky error.
    do_reset();
    refill({2'd0, 3'd1}, DataC);
    tick();
    idle();
    chk("t7_err_set", err, 1);
    chk("t7_no_crdt", crdt_valid, 0);
    chk("t7_no_issue", d_valid, 0);
    tick();
    tick();
    chk("t7_err_sticky", err, 1);
    do_reset();
    chk("t7_err_cleared", err, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
